step_mode_detector: RTL and testbench

STEP_MODE_DETECTOR -- requirements
Module: step_mode_detector

---
 rtl/step_mode_detector.sv | 161 ++++++++++++++++
 tb/tb_step_mode_detector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/step_mode_detector.sv
// Step-mode detector: classifies successive deltas of a 12-bit counter stream
// and locks onto a consistent step size (0, 1, 4 or 8).
module step_mode_detector #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [11:0] in_val,
  output logic [1:0]  mode_out,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_cnt
);

  // state  | meaning
  // IDLE   | no reference sample yet; next valid sample only loads prev_val
  // ACQ    | counting consecutive matching deltas against cand
  // LOCKED | mode_out valid; counting consecutive mismatches in miss_cnt
  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

  localparam logic [3:0] LOCK_TH = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TH = 4'(LOSS_CNT);

  state_t      state_q, state_d;
  logic [11:0] prev_q, prev_d;
  logic [1:0]  cand_q, cand_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  miss_q, miss_d;
  logic [1:0]  mode_q, mode_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [11:0] delta;
  logic [1:0]  cls;
  logic        cls_ok;
  logic [3:0]  match_inc;
  logic [3:0]  miss_inc;

  assign delta     = in_val - prev_q;
  assign match_inc = match_q + 4'd1;
  assign miss_inc  = miss_q + 4'd1;

  always_comb begin
    cls    = 2'b00;
    cls_ok = 1'b1;
    case (delta)
      12'd0:   cls = 2'b00;
      12'd1:   cls = 2'b01;
      12'd4:   cls = 2'b10;
      12'd8:   cls = 2'b11;
      default: cls_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    cand_d    = cand_q;
    match_d   = match_q;
    miss_d    = miss_q;
    mode_d    = mode_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (in_valid) begin
      prev_d = in_val;
      case (state_q)
        S_IDLE: begin
          state_d = S_ACQ;
          match_d = 4'd0;
        end
        S_ACQ: begin
          if (!cls_ok) begin
            match_d = 4'd0;
            err_d   = 1'b1;
          end else if (cls == cand_q && match_q != 4'd0) begin
            match_d = match_inc;
            if (match_inc == LOCK_TH) begin
              state_d  = S_LOCKED;
              mode_d   = cand_q;
              locked_d = 1'b1;
              miss_d   = 4'd0;
              match_d  = 4'd0;
            end
          end else begin
            cand_d  = cls;
            match_d = 4'd1;
          end
        end
        S_LOCKED: begin
          if (cls_ok && cls == mode_q) begin
            miss_d = 4'd0;
          end else begin
            miss_d = miss_inc;
            err_d  = 1'b1;
            if (miss_inc == LOSS_TH) begin
              // Dropping lock seeds acquisition with the offending delta.
              state_d  = S_ACQ;
              locked_d = 1'b0;
              miss_d   = 4'd0;
              cand_d   = cls_ok ? cls : cand_q;
              match_d  = cls_ok ? 4'd1 : 4'd0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    if (clr) begin
      state_d   = S_IDLE;
      prev_d    = prev_q;
      cand_d    = cand_q;
      match_d   = 4'd0;
      miss_d    = 4'd0;
      mode_d    = 2'b00;
      locked_d  = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      prev_q    <= 12'd0;
      cand_q    <= 2'b00;
      match_q   <= 4'd0;
      miss_q    <= 4'd0;
      mode_q    <= 2'b00;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      mode_q    <= mode_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign mode_out = mode_q;
  assign locked   = locked_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_step_mode_detector.sv
// Directed bench for step_mode_detector: lock, wrap, loss, glitch, err
// saturation, clear and asynchronous reset.
module tb_step_mode_detector;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [11:0] in_val;
  logic [1:0]  mode_out;
  logic        locked;
  logic        err;
  logic [7:0]  err_cnt;

  int passed = 0;
  int total  = 0;

  step_mode_detector #(.LOCK_CNT(4), .LOSS_CNT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_val   (in_val),
    .mode_out (mode_out),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Outputs: {mode_out, locked, err}
  task automatic chk_out(input string tag, input logic [1:0] m, input logic l, input logic e);
    chk(tag, {28'd0, mode_out, locked, err}, {28'd0, m, l, e});
  endtask

  task automatic smp(input logic [11:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_val   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_val   = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset_out", 2'b00, 1'b0, 1'b0);
    chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock on step 1
    smp(12'd100);
    chk_out("lock_first", 2'b00, 1'b0, 1'b0);
    smp(12'd101);
    smp(12'd102);
    smp(12'd103);
    chk_out("lock_pre", 2'b00, 1'b0, 1'b0);
    smp(12'd104);
    chk_out("lock_done", 2'b01, 1'b1, 1'b0);
    chk("lock_err_cnt", {24'd0, err_cnt}, 32'd0);
    idle_cycle();
    chk_out("lock_hold", 2'b01, 1'b1, 1'b0);

    // Clear concurrent with a valid sample while locked
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_val = 12'd5;
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    chk_out("clr_out", 2'b00, 1'b0, 1'b0);
    chk("clr_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Single glitch while locked on step 1 at 10
    smp(12'd6);
    smp(12'd7);
    smp(12'd8);
    smp(12'd9);
    smp(12'd10);
    chk_out("glitch_lock", 2'b01, 1'b1, 1'b0);
    smp(12'd11);
    chk_out("glitch_11", 2'b01, 1'b1, 1'b0);
    smp(12'd15);
    chk_out("glitch_15", 2'b01, 1'b1, 1'b1);
    chk("glitch_err_cnt", {24'd0, err_cnt}, 32'd1);
    idle_cycle();
    chk_out("glitch_idle", 2'b01, 1'b1, 1'b0);
    chk("glitch_idle_cnt", {24'd0, err_cnt}, 32'd1);
    smp(12'd16);
    chk_out("glitch_16", 2'b01, 1'b1, 1'b0);
    smp(12'd17);
    smp(12'd21);
    chk_out("glitch_21", 2'b01, 1'b1, 1'b1);
    smp(12'd22);
    chk_out("glitch_22", 2'b01, 1'b1, 1'b0);
    chk("glitch_err_cnt2", {24'd0, err_cnt}, 32'd2);

    // Loss of lock on step 4 at 20
    do_clr();
    smp(12'd4);
    smp(12'd8);
    smp(12'd12);
    smp(12'd16);
    smp(12'd20);
    chk_out("loss_lock", 2'b10, 1'b1, 1'b0);
    smp(12'd21);
    chk_out("loss_21", 2'b10, 1'b1, 1'b1);
    smp(12'd22);
    chk_out("loss_22", 2'b10, 1'b0, 1'b1);
    chk("loss_err_cnt", {24'd0, err_cnt}, 32'd2);
    smp(12'd23);
    smp(12'd24);
    chk_out("reacq_24", 2'b10, 1'b0, 1'b0);
    smp(12'd25);
    chk_out("reacq_25", 2'b01, 1'b1, 1'b0);

    // Wrap-around on step 8
    do_clr();
    smp(12'd4056);
    smp(12'd4064);
    smp(12'd4072);
    smp(12'd4080);
    smp(12'd4088);
    chk_out("wrap_lock", 2'b11, 1'b1, 1'b0);
    smp(12'd0);
    chk_out("wrap_0", 2'b11, 1'b1, 1'b0);
    smp(12'd8);
    chk_out("wrap_8", 2'b11, 1'b1, 1'b0);
    chk("wrap_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Illegal deltas in ACQ and err_cnt saturation
    do_clr();
    smp(12'd0);
    chk_out("ill_0", 2'b00, 1'b0, 1'b0);
    smp(12'd3);
    chk_out("ill_3", 2'b00, 1'b0, 1'b1);
    smp(12'd6);
    chk_out("ill_6", 2'b00, 1'b0, 1'b1);
    chk("ill_err_cnt", {24'd0, err_cnt}, 32'd2);
    smp(12'd7);
    chk_out("ill_7", 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      smp(12'(7 + 3 * (i + 1)));
      if (i == 99) chk("sat_mid", {24'd0, err_cnt}, 32'd102);
      if (i == 250) chk("sat_near", {24'd0, err_cnt}, 32'd253);
    end
    chk_out("sat_err", 2'b00, 1'b0, 1'b1);
    chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

    // Asynchronous reset mid-ACQ
    do_clr();
    smp(12'd50);
    smp(12'd51);
    smp(12'd60);
    chk_out("arst_pre", 2'b00, 1'b0, 1'b1);
    chk("arst_pre_cnt", {24'd0, err_cnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst_now", 2'b00, 1'b0, 1'b0);
    chk("arst_now_cnt", {24'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    smp(12'd61);
    chk_out("arst_first", 2'b00, 1'b0, 1'b0);
    smp(12'd69);
    smp(12'd77);
    smp(12'd85);
    smp(12'd93);
    chk_out("arst_relock", 2'b11, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
